// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared types and constants for the DRAM arbiter and sequencer
//
// Purpose: arbitration state encoding, sequencer owner codes, default
// refresh interval and the width of the postponed-refresh counter.
// Ports: none (package).
package dram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  // 50 MHz clock, 7.8 us refresh interval less margin.
  localparam int REFRESH_CYCLE_CNT_DEFAULT = 374;

  localparam int PEND_W = 3;

endpackage

// File: rtl/dram_refresh_sched.sv
// rtl/dram_refresh_sched.sv - refresh interval timer, postponed-refresh counter, overrun flag
//
// Purpose: counts CLK cycles 0..REFRESH_CYCLE_CNT, emitting a one-cycle tick
// on the terminal count; keeps a saturating backlog of refreshes still owed.
// Ports:
//   CLK, nRST  clock, asynchronous active-low reset
//   consume    a refresh operation finished this cycle (decrements backlog)
//   tick       one-cycle pulse, refresh interval elapsed
//   pending    refreshes owed, saturates at MAX_PENDING
//   overrun    sticky: a tick arrived while the backlog was already full
module dram_refresh_sched
  import dram_pkg::*;
#(
  parameter int REFRESH_CYCLE_CNT = REFRESH_CYCLE_CNT_DEFAULT,
  parameter int MAX_PENDING       = 4,
  parameter int CNT_W             = 12
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              consume,
  output logic              tick,
  output logic [PEND_W-1:0] pending,
  output logic              overrun
);

  localparam logic [CNT_W-1:0]  TIMER_TOP = CNT_W'(REFRESH_CYCLE_CNT);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);

  logic [CNT_W-1:0]  r_timer;
  logic [PEND_W-1:0] r_pending;
  logic              r_overrun;

  assign tick    = (r_timer == TIMER_TOP);
  assign pending = r_pending;
  assign overrun = r_overrun;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_timer   <= '0;
      r_pending <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_timer <= tick ? '0 : r_timer + 1'b1;

      if (tick && (r_pending == PEND_MAX)) begin
        r_overrun <= 1'b1;
      end

      // A tick and a completed refresh in the same cycle cancel out.
      if (tick && !consume) begin
        if (r_pending != PEND_MAX) begin
          r_pending <= r_pending + 1'b1;
        end
      end else if (consume && !tick && (r_pending != '0)) begin
        r_pending <= r_pending - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - shares the DRAM sequencer between CPU, DMA and refresh
//
// Purpose: round-robin CPU/DMA arbitration with refresh insertion; issues one
// operation at a time over a seq_start/seq_done handshake.
// Ports:
//   CLK, nRST        clock, asynchronous active-low reset
//   cpu_req/cpu_ack  CPU 4-phase access handshake
//   dma_req/dma_ack  DMA 4-phase access handshake
//   seq_start        one-cycle pulse starting a sequencer operation
//   seq_refresh      1 = CBR refresh, held through the operation
//   seq_owner        0 = CPU, 1 = DMA, held through the operation
//   seq_done         one-cycle pulse, sequencer operation complete
//   refresh_pending  postponed refresh count
//   refresh_overrun  sticky backlog overflow flag
module dram_arbiter
  import dram_pkg::*;
#(
  parameter int REFRESH_CYCLE_CNT = REFRESH_CYCLE_CNT_DEFAULT,
  parameter int MAX_PENDING       = 4,
  parameter int CNT_W             = 12
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              cpu_req,
  output logic              cpu_ack,
  input  logic              dma_req,
  output logic              dma_ack,
  output logic              seq_start,
  output logic              seq_refresh,
  output logic              seq_owner,
  input  logic              seq_done,
  output logic [PEND_W-1:0] refresh_pending,
  output logic              refresh_overrun
);

  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  arb_state_t r_state, w_state_nxt;
  logic r_start, w_start_nxt;
  logic r_refresh, w_refresh_nxt;
  logic r_owner, w_owner_nxt;
  logic r_cpu_ack, w_cpu_ack_nxt;
  logic r_dma_ack, w_dma_ack_nxt;
  logic r_last_grant, w_last_nxt;

  logic w_tick;
  logic w_consume;
  logic w_pick;
  logic w_owner_req;

  assign w_consume   = (r_state == ST_BUSY) && seq_done && r_refresh;
  // On a tie the requester that was not served last wins.
  assign w_pick      = (cpu_req && dma_req) ? ~r_last_grant
                                            : (cpu_req ? OWNER_CPU : OWNER_DMA);
  assign w_owner_req = (r_owner == OWNER_DMA) ? dma_req : cpu_req;

  dram_refresh_sched #(
    .REFRESH_CYCLE_CNT (REFRESH_CYCLE_CNT),
    .MAX_PENDING       (MAX_PENDING),
    .CNT_W             (CNT_W)
  ) u_sched (
    .CLK     (CLK),
    .nRST    (nRST),
    .consume (w_consume),
    .tick    (w_tick),
    .pending (refresh_pending),
    .overrun (refresh_overrun)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= ST_IDLE;
      r_start      <= 1'b0;
      r_refresh    <= 1'b0;
      r_owner      <= OWNER_CPU;
      r_cpu_ack    <= 1'b0;
      r_dma_ack    <= 1'b0;
      r_last_grant <= OWNER_DMA;
    end else begin
      r_state      <= w_state_nxt;
      r_start      <= w_start_nxt;
      r_refresh    <= w_refresh_nxt;
      r_owner      <= w_owner_nxt;
      r_cpu_ack    <= w_cpu_ack_nxt;
      r_dma_ack    <= w_dma_ack_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start_nxt   = 1'b0;
    w_refresh_nxt = r_refresh;
    w_owner_nxt   = r_owner;
    w_cpu_ack_nxt = r_cpu_ack;
    w_dma_ack_nxt = r_dma_ack;
    w_last_nxt    = r_last_grant;
    case (r_state)
      ST_IDLE: begin
        // A full backlog preempts accesses; otherwise refresh only when idle.
        if (refresh_pending == PEND_MAX) begin
          w_state_nxt   = ST_BUSY;
          w_start_nxt   = 1'b1;
          w_refresh_nxt = 1'b1;
        end else if (cpu_req || dma_req) begin
          w_state_nxt   = ST_BUSY;
          w_start_nxt   = 1'b1;
          w_refresh_nxt = 1'b0;
          w_owner_nxt   = w_pick;
        end else if (refresh_pending != '0) begin
          w_state_nxt   = ST_BUSY;
          w_start_nxt   = 1'b1;
          w_refresh_nxt = 1'b1;
        end
      end
      ST_BUSY: begin
        if (seq_done) begin
          w_refresh_nxt = 1'b0;
          if (r_refresh) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_RELEASE;
            w_last_nxt  = r_owner;
            if (r_owner == OWNER_DMA) begin
              w_dma_ack_nxt = 1'b1;
            end else begin
              w_cpu_ack_nxt = 1'b1;
            end
          end
        end
      end
      ST_RELEASE: begin
        if (!w_owner_req) begin
          w_state_nxt   = ST_IDLE;
          w_cpu_ack_nxt = 1'b0;
          w_dma_ack_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign seq_start   = r_start;
  assign seq_refresh = r_refresh;
  assign seq_owner   = r_owner;
  assign cpu_ack     = r_cpu_ack;
  assign dma_ack     = r_dma_ack;

  // A tick that finds the backlog full must leave the overrun flag set.
  a_overrun_on_full_tick: assert property (@(posedge CLK) disable iff (!nRST)
    (w_tick && (refresh_pending == PEND_MAX)) |=> refresh_overrun);

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - self-checking bench for dram_arbiter
module tb_dram_arbiter;

  localparam int RCC  = 20;
  localparam int MAXP = 4;
  localparam int CW   = 12;

  localparam int FREE  = -1;
  localparam int H_CPU = 0;
  localparam int H_DMA = 1;
  localparam int H_REF = 2;

  logic       CLK, nRST;
  logic       cpu_req, dma_req, seq_done;
  logic       cpu_ack, dma_ack, seq_start, seq_refresh, seq_owner, refresh_overrun;
  logic [2:0] refresh_pending;

  int checks   = 0;
  int failures = 0;

  bit cmp_en   = 0;
  bit cpu_auto = 0;
  bit dma_auto = 0;
  bit stall    = 0;
  int seq_cnt  = 0;
  int grants[$];
  int n;

  dram_arbiter #(
    .REFRESH_CYCLE_CNT (RCC),
    .MAX_PENDING       (MAXP),
    .CNT_W             (CW)
  ) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .cpu_req         (cpu_req),
    .cpu_ack         (cpu_ack),
    .dma_req         (dma_req),
    .dma_ack         (dma_ack),
    .seq_start       (seq_start),
    .seq_refresh     (seq_refresh),
    .seq_owner       (seq_owner),
    .seq_done        (seq_done),
    .refresh_pending (refresh_pending),
    .refresh_overrun (refresh_overrun)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds the sequencer, whether they have been
  // acknowledged, and how many refreshes are owed.
  int m_timer, m_pend, m_holder, m_last, m_owner;
  bit m_ovr, m_start, m_acked;

  always @(posedge CLK or negedge nRST) begin : model_b
    int  old_pend;
    int  who;
    bit  tick;
    bit  consume;
    if (!nRST) begin
      m_timer  = 0;
      m_pend   = 0;
      m_ovr    = 0;
      m_holder = FREE;
      m_last   = H_DMA;
      m_start  = 0;
      m_acked  = 0;
      m_owner  = 0;
    end else begin
      old_pend = m_pend;
      tick     = (m_timer == RCC);
      consume  = (m_holder == H_REF) && (seq_done === 1'b1);
      m_start  = 0;
      if (m_holder == FREE) begin
        if (old_pend == MAXP) begin
          m_holder = H_REF;
          m_start  = 1;
        end else if (cpu_req || dma_req) begin
          if (cpu_req && dma_req) who = 1 - m_last;
          else who = dma_req ? H_DMA : H_CPU;
          m_holder = who;
          m_owner  = who;
          m_start  = 1;
        end else if (old_pend > 0) begin
          m_holder = H_REF;
          m_start  = 1;
        end
      end else if (!m_acked) begin
        if (seq_done) begin
          if (m_holder == H_REF) begin
            m_holder = FREE;
          end else begin
            m_acked = 1;
            m_last  = m_holder;
          end
        end
      end else begin
        if (!((m_holder == H_CPU) ? cpu_req : dma_req)) begin
          m_acked  = 0;
          m_holder = FREE;
        end
      end
      if (tick && old_pend == MAXP) m_ovr = 1;
      if (tick && !consume) begin
        if (old_pend < MAXP) m_pend = old_pend + 1;
      end else if (consume && !tick) begin
        m_pend = old_pend - 1;
      end
      m_timer = tick ? 0 : m_timer + 1;
    end
  end

  always begin
    @(posedge CLK);
    #1;
    if (cmp_en) begin
      chk("seq_start", seq_start, m_start);
      chk("seq_refresh", seq_refresh, (m_holder == H_REF));
      if (m_holder == H_CPU || m_holder == H_DMA) chk("seq_owner", seq_owner, m_owner);
      chk("cpu_ack", cpu_ack, (m_acked && m_holder == H_CPU));
      chk("dma_ack", dma_ack, (m_acked && m_holder == H_DMA));
      chk("refresh_pending", refresh_pending, m_pend);
      chk("refresh_overrun", refresh_overrun, m_ovr);
    end
  end

  // One clock of environment: sequencer responder and 4-phase request agents.
  task automatic cyc();
    @(negedge CLK);
    seq_done = 1'b0;
    if (!nRST) begin
      seq_cnt = 0;
    end else begin
      if (seq_cnt > 0) begin
        if (!(seq_cnt == 1 && stall)) begin
          seq_cnt--;
          if (seq_cnt == 0) seq_done = 1'b1;
        end
      end
      if (seq_start) begin
        seq_cnt = 5;
        if (!seq_refresh) grants.push_back(int'(seq_owner));
      end
    end
    if (cpu_auto) begin
      if (!cpu_req && !cpu_ack) cpu_req = 1'b1;
      else if (cpu_req && cpu_ack) cpu_req = 1'b0;
    end
    if (dma_auto) begin
      if (!dma_req && !dma_ack) dma_req = 1'b1;
      else if (dma_req && dma_ack) dma_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    cmp_en   = 0;
    cpu_auto = 0;
    dma_auto = 0;
    stall    = 0;
    cpu_req  = 1'b0;
    dma_req  = 1'b0;
    seq_done = 1'b0;
    seq_cnt  = 0;
    grants.delete();
    nRST = 1'b0;
    cyc();
    cyc();
    nRST   = 1'b1;
    cmp_en = 1;
  endtask

  initial begin
    nRST     = 1'b0;
    cpu_req  = 1'b0;
    dma_req  = 1'b0;
    seq_done = 1'b0;

    // Single CPU access: latency and 4-phase release.
    do_reset();
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_dma_ack", dma_ack, 0);
    chk("rst_seq_start", seq_start, 0);
    chk("rst_seq_refresh", seq_refresh, 0);
    chk("rst_seq_owner", seq_owner, 0);
    chk("rst_pending", refresh_pending, 0);
    chk("rst_overrun", refresh_overrun, 0);
    cpu_req = 1'b1;
    cyc();
    chk("t1_start", seq_start, 1);
    chk("t1_owner", seq_owner, 0);
    chk("t1_refresh", seq_refresh, 0);
    repeat (5) cyc();
    chk("t1_ack_not_yet", cpu_ack, 0);
    cyc();
    chk("t1_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    cyc();
    chk("t1_ack_drop", cpu_ack, 0);

    // Both requesters continuously re-requesting: strict alternation, CPU first.
    do_reset();
    cpu_auto = 1;
    dma_auto = 1;
    n = 0;
    while (grants.size() < 4 && n < 200) begin cyc(); n++; end
    chk("t2_grants_seen", (grants.size() >= 4), 1);
    if (grants.size() >= 4) begin
      chk("t2_grant0", grants[0], 0);
      chk("t2_grant1", grants[1], 1);
      chk("t2_grant2", grants[2], 0);
      chk("t2_grant3", grants[3], 1);
    end

    // Idle-time refresh.
    do_reset();
    repeat (20) cyc();
    chk("t3_pend_before_tick", refresh_pending, 0);
    cyc();
    chk("t3_pend_after_tick", refresh_pending, 1);
    chk("t3_no_start_yet", seq_start, 0);
    cyc();
    chk("t3_ref_start", seq_start, 1);
    chk("t3_ref_flag", seq_refresh, 1);
    repeat (5) cyc();
    chk("t3_pend_during_op", refresh_pending, 1);
    cyc();
    chk("t3_pend_drained", refresh_pending, 0);
    chk("t3_ref_cleared", seq_refresh, 0);

    // DMA hogging: backlog fills, forced refresh wins over DMA.
    do_reset();
    dma_auto = 1;
    n = 0;
    while (refresh_pending != 3'd4 && n < 300) begin cyc(); n++; end
    chk("t4_pend_reached_max", refresh_pending, 4);
    cyc();
    n = 0;
    while (!seq_start && n < 40) begin cyc(); n++; end
    chk("t4_forced_start", seq_start, 1);
    chk("t4_forced_is_refresh", seq_refresh, 1);
    repeat (60) cyc();
    chk("t4_no_overrun", refresh_overrun, 0);

    // Stalled sequencer: backlog overflows, overrun is sticky.
    do_reset();
    stall = 1;
    n = 0;
    while (!refresh_overrun && n < 200) begin cyc(); n++; end
    chk("t5_overrun_set", refresh_overrun, 1);
    chk("t5_pend_at_max", refresh_pending, 4);
    stall = 0;
    n = 0;
    while (refresh_pending != 3'd0 && n < 300) begin cyc(); n++; end
    chk("t5_drained", refresh_pending, 0);
    chk("t5_overrun_sticky", refresh_overrun, 1);

    // Asynchronous reset mid-operation, then tie goes to the CPU.
    do_reset();
    cpu_req = 1'b1;
    n = 0;
    while (!cpu_ack && n < 30) begin cyc(); n++; end
    chk("t6_first_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    cyc();
    cpu_req = 1'b1;
    cyc();
    cyc();
    cyc();
    #2;
    nRST = 1'b0;
    #1;
    chk("t6_async_cpu_ack", cpu_ack, 0);
    chk("t6_async_dma_ack", dma_ack, 0);
    chk("t6_async_start", seq_start, 0);
    chk("t6_async_refresh", seq_refresh, 0);
    chk("t6_async_owner", seq_owner, 0);
    chk("t6_async_pending", refresh_pending, 0);
    chk("t6_async_overrun", refresh_overrun, 0);
    cpu_req = 1'b0;
    seq_cnt = 0;
    cyc();
    nRST = 1'b1;
    grants.delete();
    cpu_auto = 1;
    dma_auto = 1;
    n = 0;
    while (grants.size() < 1 && n < 50) begin cyc(); n++; end
    chk("t6_grant_seen", (grants.size() >= 1), 1);
    if (grants.size() >= 1) chk("t6_tie_to_cpu", grants[0], 0);

    repeat (3) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
